// File: rtl/mips_bus_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM state encoding,
// bus size codes and watchdog defaults.
package mips_bus_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bus_state_e;

  // Bus transfer size codes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Watchdog defaults
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
  localparam int unsigned WDOG_CNT_W         = 16;

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog for data_sram_bridge. Only present when
// DATA_SRAM_BRIDGE_TIMEOUT_EN is defined.
`ifdef DATA_SRAM_BRIDGE_TIMEOUT_EN
module bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expire_c
);

  logic [WDOG_CNT_W-1:0] count;

  // Cycle counter: cleared when a request is issued, counts while it is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active) begin
      count <= count + WDOG_CNT_W'(1);
    end
  end

  // Fires on the cycle whose closing edge is the TIMEOUT_CYCLES-th since issue
  assign expire_c = active & (count == WDOG_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/data_sram_bridge.sv
// M-stage data-memory bridge: turns a single-cycle memory request into a
// two-phase (addr_ok, data_ok) SRAM-like bus transaction and stalls the
// pipeline until it completes. Optional watchdog: DATA_SRAM_BRIDGE_TIMEOUT_EN.
module data_sram_bridge
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [1:0]        mem_sizeM,
  input  logic [ADDR_W-1:0] mem_addrM,
  input  logic [DATA_W-1:0] mem_wdataM,
  input  logic              flushM,
  input  logic              advanceM,
  output logic [DATA_W-1:0] mem_rdataM,
  output logic              stall_memM,
  output logic              bus_errM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  // The watchdog counter must be able to reach TIMEOUT_CYCLES-1
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << WDOG_CNT_W)) begin : g_bad_timeout
    $error("data_sram_bridge: TIMEOUT_CYCLES out of range");
  end

  bus_state_e state;
  logic       cancel;
  logic       issue_c;
  logic       busy_c;
  logic       drop_c;
  logic       complete_c;
  logic       expire_c;

  assign issue_c    = (state == IDLE) & memenM & ~flushM;
  assign busy_c     = (state == REQ) | (state == WAIT);
  // A flush in the final bus cycle still discards the result
  assign drop_c     = cancel | flushM;
  assign complete_c = ((state == REQ) & data_addr_ok & data_data_ok) |
                      ((state == WAIT) & data_data_ok);

  assign stall_memM = issue_c | busy_c;

`ifdef DATA_SRAM_BRIDGE_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .start    (issue_c),
    .active   (busy_c),
    .expire_c (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  // Bridge FSM with registered bus and M-stage outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      mem_rdataM <= '0;
      bus_errM   <= 1'b0;
    end else begin
      bus_errM <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_c) begin
            state      <= REQ;
            cancel     <= 1'b0;
            data_req   <= 1'b1;
            data_wr    <= memwriteM;
            data_size  <= mem_sizeM;
            data_addr  <= mem_addrM;
            data_wdata <= mem_wdataM;
          end
        end
        REQ, WAIT: begin
          if (complete_c) begin
            data_req <= 1'b0;
            cancel   <= 1'b0;
            state    <= drop_c ? IDLE : DONE;
            if (!drop_c && !data_wr) begin
              mem_rdataM <= data_rdata;
            end
          end else if (expire_c) begin
            data_req   <= 1'b0;
            cancel     <= 1'b0;
            bus_errM   <= 1'b1;
            mem_rdataM <= '0;
            state      <= drop_c ? IDLE : DONE;
          end else begin
            cancel <= drop_c;
            if ((state == REQ) && data_addr_ok) begin
              data_req <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        DONE: begin
          if (advanceM || flushM) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Memory-stage responder for the pipeline's data-memory request signals (memenM, memwriteM) issued by the pipeline controller.
- Converts each single-cycle M-stage request into a two-phase SRAM-like bus transaction: a request/addr_ok phase, then a data_ok phase.
- Stalls the pipeline until the transaction completes and returns load data to the M stage.
- Sits between the datapath M stage and the external data bus/cache.

Parameters:
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when the optional feature is compiled in.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- memenM  in  1  M-stage memory access valid
- memwriteM  in  1  1=store, 0=load
- mem_sizeM  in  2  0=byte, 1=half, 2=word
- mem_addrM  in  ADDR_W  byte address
- mem_wdataM  in  DATA_W  store data
- flushM  in  1  M-stage instruction squashed (exception/redirect)
- advanceM  in  1  pipeline latches the next M-stage instruction at this edge
- mem_rdataM  out  DATA_W  load data, valid in DONE
- stall_memM  out  1  bridge busy; hold pipeline
- bus_errM  out  1  one-cycle pulse on watchdog expiry; constant 0 when the feature is absent
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  ADDR_W  bus address
- data_wdata  out  DATA_W  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cancel=0.
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0.
  - mem_rdataM=0, bus_errM=0.
  - stall_memM follows the IDLE combinational rule.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - memenM & ~flushM -> REQ next edge.
  - On that edge, latch addr, wdata, wr and size into the data_* registers and set data_req=1.
- REQ:
  - data_req held at 1 with all data_* fields stable until data_addr_ok.
  - addr_ok & ~data_ok -> WAIT, data_req=0.
  - addr_ok & data_ok in the same cycle -> DONE (or IDLE if cancel).
- WAIT:
  - data_ok -> DONE (or IDLE if cancel).
  - On a load, capture data_rdata into mem_rdataM; stores leave mem_rdataM unchanged.
- DONE:
  - Result held.
  - advanceM -> IDLE; otherwise stay in DONE with no re-issue.
- stall_memM = (IDLE & memenM & ~flushM) | REQ | WAIT; 0 in DONE.
- Minimum latency, with addr_ok in the REQ cycle and data_ok the next cycle:
  - stall high for 3 cycles (IDLE, REQ, WAIT); low in the 4th cycle (DONE).
- flushM during REQ or WAIT:
  - An issued request is never withdrawn; set cancel=1.
  - Complete the transaction normally, discard the result, return to IDLE with cancel=0.
  - stall_memM stays high until the drain finishes.
- flushM in DONE -> IDLE.
- flushM in IDLE with memenM -> no request.
- data_ok while in IDLE or DONE: ignored.
- Size/address alignment is the datapath's responsibility; the bridge passes fields through unmodified.

Optional Feature:
- Macro: DATA_SRAM_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering REQ and increments in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES: force data_req=0, pulse bus_errM for 1 cycle, set mem_rdataM=0, go to DONE (IDLE if cancel).
- Not defined: no counter; bus_errM tied to 0; REQ/WAIT wait indefinitely.

Decomposition:
- Shared package mips_bus_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3);
  - the size encodings (SIZE_B/SIZE_H/SIZE_W);
  - the default TIMEOUT_CYCLES.
- One sub-module is natural: bus_watchdog (counter plus expiry pulse), instantiated only under the macro.

Test Plan:
- Word load to 0x0000_1000; addr_ok at cycle 1; data_ok with rdata=0xDEADBEEF at cycle 2 -> stall_memM high for cycles 0-2, mem_rdataM=0xDEADBEEF and stall low at cycle 3; no second data_req after advanceM.
- Byte store of wdata=0x0000_00A5 to 0x0000_2003 with addr_ok delayed 4 cycles -> data_req, data_wr=1, data_size=0 and data_addr=0x0000_2003 stable for all 5 REQ cycles; stall released the cycle after data_ok.
- addr_ok and data_ok in the same cycle with rdata=0x1234_5678 -> REQ goes directly to DONE; mem_rdataM=0x1234_5678.
- flushM in WAIT, then data_ok with rdata=0xFFFF_FFFF -> mem_rdataM unchanged; returns to IDLE; no DONE cycle; a following load issues normally.
- Assert rst asynchronously mid-WAIT -> data_req=0 and state=IDLE immediately, without waiting for a clock edge.
- With DATA_SRAM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, addr_ok never asserted -> bus_errM pulses for exactly 1 cycle 8 cycles after the REQ entry edge; data_req drops; mem_rdataM=0.
